// File: rtl/normalize_sp_pkg.sv
// Shared FPU definitions for the single-precision normalizer.
// Provides the exponent/mantissa/result widths, the default exponent
// bias and the normalizer FSM state encoding.
package normalize_sp_pkg;

  localparam int EXP_W      = 10;
  localparam int MANT_W     = 48;
  localparam int FRAC_W     = 23;
  localparam int EXP_FRAC_W = EXP_W + FRAC_W;
  localparam int FPU_BIAS   = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/normalize_sp_lzc_step.sv
// Leading-zero counter over one left-shift window.
// Ports:
//   bits  - window, bits[W-1] is the most significant position
//   count - number of leading zeros, W when the window is all zero
module lzc_step #(
  parameter int W   = 4,
  parameter int CW  = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (bits[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/normalize_sp.sv
// Post-add/multiply normalizer for single precision. Takes a sign, a
// signed biased exponent and a 48-bit mantissa (binary point between
// bits 46 and 45), shifts it to normal or subnormal form one step per
// cycle and presents the pre-rounding exponent/fraction plus guard,
// round and sticky bits to the rounding stage.
// Ports:
//   CLK, RESET             - clock, synchronous active-high reset
//   IN_VALID/IN_READY      - operand handshake (accepted only in IDLE)
//   IN_SIGN/IN_EXP/IN_MANT - operand
//   OUT_VALID/OUT_READY    - result handshake (result held until taken)
//   OUT_SIGN, EXP_FRAC     - sign, {exp[9:0], frac[22:0]}
//   Guard_Bits             - {guard, round, sticky}
//   OUT_ZERO               - result is exactly zero
//
// state | meaning
// IDLE  | waiting for an operand, IN_READY high
// NORM  | one right or left shift step per cycle until normalized
// DONE  | result valid, held until OUT_READY
module normalize_sp
  import normalize_sp_pkg::*;
#(
  parameter int BIAS        = FPU_BIAS,
  parameter int LSHIFT_STEP = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  IN_SIGN,
  input  logic [EXP_W-1:0]      IN_EXP,
  input  logic [MANT_W-1:0]     IN_MANT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_SIGN,
  output logic [EXP_FRAC_W-1:0] EXP_FRAC,
  output logic [2:0]            Guard_Bits,
  output logic                  OUT_ZERO
);

  localparam int LZ_W      = $clog2(LSHIFT_STEP + 1);
  localparam int GUARD_BIT = MANT_W - 3 - FRAC_W;

  // Biased encoding of the minimum normal exponent (1 - BIAS unbiased).
  localparam logic signed [EXP_W-1:0] CLAMP_EXP = EXP_W'(BIAS - (BIAS - 1));
  localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  // Below this exponent every mantissa bit would be shifted out anyway.
  localparam logic signed [EXP_W-1:0] UFLOW_LIM = EXP_W'(-MANT_W);

  norm_state_e              state_q, state_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic                     sticky_q, sticky_d;
  logic                     sign_q, sign_d;

  logic signed [EXP_W-1:0]  in_exp_s;
  logic [LZ_W-1:0]          lz_cnt;
  logic [EXP_W-1:0]         exp_m1;
  logic [LZ_W-1:0]          shamt;
  logic signed [EXP_W-1:0]  shift_exp;

  assign in_exp_s = $signed(IN_EXP);

  lzc_step #(
    .W  (LSHIFT_STEP),
    .CW (LZ_W)
  ) u_lzc (
    .bits  (mant_q[MANT_W-2 -: LSHIFT_STEP]),
    .count (lz_cnt)
  );

  // Left shift is only taken when exp > 1, so exp-1 is positive and an
  // unsigned compare against the zero count is safe.
  assign exp_m1    = exp_q - EXP_ONE;
  assign shamt     = (exp_m1 < EXP_W'(lz_cnt)) ? exp_m1[LZ_W-1:0] : lz_cnt;
  assign shift_exp = $signed(EXP_W'(shamt));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    unique case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          sign_d   = IN_SIGN;
          sticky_d = 1'b0;
          state_d  = ST_NORM;
          if (in_exp_s < UFLOW_LIM) begin
            mant_d   = '0;
            exp_d    = CLAMP_EXP;
            sticky_d = |IN_MANT;
          end else begin
            mant_d = IN_MANT;
            exp_d  = in_exp_s;
          end
        end
      end
      ST_NORM: begin
        if (mant_q == '0) begin
          state_d = ST_DONE;
        end else if (mant_q[MANT_W-1] || (exp_q < EXP_ONE)) begin
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + EXP_ONE;
          sticky_d = sticky_q | mant_q[0];
        end else if (!mant_q[MANT_W-2] && (exp_q > EXP_ONE)) begin
          mant_d = mant_q << shamt;
          exp_d  = exp_q - shift_exp;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign IN_READY   = (state_q == ST_IDLE);
  assign OUT_VALID  = (state_q == ST_DONE);
  assign OUT_SIGN   = sign_q;
  // A clear hidden bit means subnormal or zero: exponent field reads 0.
  assign EXP_FRAC   = {(mant_q[MANT_W-2] ? exp_q : '0), mant_q[MANT_W-3 -: FRAC_W]};
  assign Guard_Bits = {mant_q[GUARD_BIT], mant_q[GUARD_BIT-1],
                       (|mant_q[GUARD_BIT-2:0]) | sticky_q};
  assign OUT_ZERO   = (mant_q == '0) && !sticky_q;

endmodule

// File: tb/tb_normalize_sp.sv
module tb_normalize_sp;

  localparam int STEP = 4;

  logic        CLK;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_SIGN;
  logic [9:0]  IN_EXP;
  logic [47:0] IN_MANT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_SIGN;
  logic [32:0] EXP_FRAC;
  logic [2:0]  Guard_Bits;
  logic        OUT_ZERO;

  int n_checks = 0;
  int n_errors = 0;

  normalize_sp #(.BIAS(127), .LSHIFT_STEP(STEP)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_SIGN    (IN_SIGN),
    .IN_EXP     (IN_EXP),
    .IN_MANT    (IN_MANT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_SIGN   (OUT_SIGN),
    .EXP_FRAC   (EXP_FRAC),
    .Guard_Bits (Guard_Bits),
    .OUT_ZERO   (OUT_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [32:0] ef;
    logic [2:0]  gb;
    logic        zero;
    int          steps;
  } res_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Closed-form result: how far the mantissa must move and where it ends up,
  // derived from the value rather than from a cycle-by-cycle walk.
  function automatic res_t model(input int e, input logic [47:0] m);
    res_t r;
    logic [47:0] mm;
    logic st;
    int ee, msb, rs, lz, s;
    st = 1'b0; mm = m; ee = e; r.steps = 0;
    if (e < -48) begin
      mm = '0; ee = 1; st = |m;
    end else if (m != 0) begin
      msb = 47;
      while (!m[msb]) msb--;
      rs = 1 - e;
      if (m[47] && rs < 1) rs = 1;
      if (rs < 0) rs = 0;
      if (rs > 0) begin
        if (rs > msb + 1) rs = msb + 1;   // value drains to zero; stops there
        r.steps = rs;
        for (int i = 0; i < rs; i++) st |= m[i];
        mm = m >> rs;
        ee = e + rs;
      end else begin
        lz = 46 - msb;
        s = (lz < e - 1) ? lz : e - 1;
        r.steps = (s + STEP - 1) / STEP;
        mm = m << s;
        ee = e - s;
      end
    end
    r.ef   = {(mm[46] ? 10'(ee) : 10'd0), mm[45:23]};
    r.gb   = {mm[22], mm[21], (|mm[20:0]) | st};
    r.zero = (mm == 0) && !st;
    return r;
  endfunction

  task automatic run_op(input logic s, input int e, input logic [47:0] m, input int hold);
    res_t r;
    int n;
    r = model(e, m);
    chk("in_ready_idle", 64'(IN_READY), 64'd1);
    IN_VALID = 1'b1; IN_SIGN = s; IN_EXP = 10'(e); IN_MANT = m;
    tick();
    // Busy: a competing operand must be ignored.
    IN_SIGN = ~s; IN_EXP = 10'($urandom); IN_MANT = {16'($urandom), 32'($urandom)};
    n = 0;
    while (!OUT_VALID && n < 300) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(1 + r.steps));
    chk("exp_frac", 64'(EXP_FRAC), 64'(r.ef));
    chk("guard_bits", 64'(Guard_Bits), 64'(r.gb));
    chk("out_zero", 64'(OUT_ZERO), 64'(r.zero));
    chk("out_sign", 64'(OUT_SIGN), 64'(s));
    chk("in_ready_busy", 64'(IN_READY), 64'd0);
    IN_VALID = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(OUT_VALID), 64'd1);
      chk("hold_in_ready", 64'(IN_READY), 64'd0);
      chk("hold_exp_frac", 64'(EXP_FRAC), 64'(r.ef));
      chk("hold_guard", 64'(Guard_Bits), 64'(r.gb));
    end
    OUT_READY = 1'b1;
    chk("in_ready_handoff", 64'(IN_READY), 64'd0);
    tick();
    OUT_READY = 1'b0;
    chk("post_valid", 64'(OUT_VALID), 64'd0);
    chk("post_in_ready", 64'(IN_READY), 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
    chk({tag, "_out_valid"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_exp_frac"}, 64'(EXP_FRAC), 64'd0);
    chk({tag, "_guard"}, 64'(Guard_Bits), 64'd0);
    chk({tag, "_sign"}, 64'(OUT_SIGN), 64'd0);
    chk({tag, "_zero"}, 64'(OUT_ZERO), 64'd1);
  endtask

  initial begin
    int ei;
    logic [47:0] mr;
    RESET = 1'b1; IN_VALID = 1'b0; IN_SIGN = 1'b0; IN_EXP = '0; IN_MANT = '0;
    OUT_READY = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    chk_reset_state("reset");

    // Directed vectors.
    run_op(1'b0, 127, 48'h4000_0000_0000, 0);
    run_op(1'b1, 127, 48'hC000_0000_0001, 1);
    run_op(1'b0, 127, 48'h0000_4000_0000, 0);
    run_op(1'b0, 0,   48'h4000_0000_0000, 0);
    run_op(1'b1, 127, 48'h0, 0);
    run_op(1'b0, 127, 48'h4000_0000_0000, 5);
    run_op(1'b0, 300, 48'h8000_0000_0000, 0);
    run_op(1'b0, -49, 48'h0000_0000_0001, 0);
    run_op(1'b0, -48, 48'h8000_0000_0000, 0);
    run_op(1'b0, 3,   48'h0000_0000_00F0, 0);

    // Reset while in NORM.
    IN_VALID = 1'b1; IN_SIGN = 1'b1; IN_EXP = 10'd127; IN_MANT = 48'h0000_4000_0000;
    tick();
    IN_VALID = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset_state("rst_norm");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_norm_no_result", 64'(OUT_VALID), 64'd0);
    end

    // Reset while in DONE.
    IN_VALID = 1'b1; IN_SIGN = 1'b1; IN_EXP = 10'd127; IN_MANT = 48'h4000_0000_0001;
    tick();
    IN_VALID = 1'b0;
    tick();
    chk("done_before_rst", 64'(OUT_VALID), 64'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset_state("rst_done");

    // Reset wins over a simultaneous operand.
    RESET = 1'b1; IN_VALID = 1'b1; IN_SIGN = 1'b1; IN_EXP = 10'd127;
    IN_MANT = 48'h4000_0000_0000;
    tick();
    RESET = 1'b0; IN_VALID = 1'b0;
    chk_reset_state("rst_prio");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_prio_no_result", 64'(OUT_VALID), 64'd0);
    end

    // Randomized operands.
    for (int t = 0; t < 300; t++) begin
      ei = int'($urandom_range(0, 370)) - 60;
      mr = {16'($urandom), 32'($urandom)};
      mr = mr >> $urandom_range(0, 48);
      if ($urandom_range(0, 15) == 0) mr = '0;
      run_op(1'($urandom), ei, mr, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
